load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request, sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- unsigned_ld  in  1  1 = zero-extend sub-word load, 0 = sign-extend.
- addr  in  32  byte address; bits [31:12] ignored.
- wdata  in  32  store data, right-aligned.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  one-cycle fault pulse, coincident with done.
- rdata  out  32  extended load result.
- mem_addr  out  10  word address to data memory.
- mem_din  out  32  write word to data memory.
- mem_wen  out  1  data memory write enable.
- mem_ren  out  1  data memory read enable.
- mem_dout  in  32  read word from data memory.

Function
REQ-002 The block SHALL latch addr, wdata, size, is_store and unsigned_ld on the rising edge where state=IDLE and req=1; word address = addr[11:2].
REQ-003 Byte lanes SHALL be little-endian: byte k occupies bits [8k+7:8k], half k occupies bits [16k+15:16k].
REQ-004 The FSM SHALL have states IDLE, RD, CAP, WR.
REQ-005 Transitions: load IDLE->RD->CAP->IDLE; word store IDLE->WR->IDLE; byte/half store IDLE->RD->CAP->WR->IDLE; misaligned IDLE->IDLE.
REQ-006 mem_ren SHALL be 1 in RD and CAP; mem_wen SHALL be 1 only in WR; mem_addr SHALL equal the latched word address in RD/CAP/WR, else 0; mem_din SHALL be 0 outside WR.
REQ-007 mem_dout SHALL be captured on the edge leaving CAP.
REQ-008 Word store: mem_din = latched wdata. Sub-word store: mem_din = captured word with the addressed lane replaced by wdata[7:0] or wdata[15:0], other lanes unchanged.
REQ-009 Load: on the edge leaving CAP, rdata SHALL be loaded with the selected lane, sign- or zero-extended per unsigned_ld (word unmodified); rdata SHALL hold until the next completed load or reset.
REQ-010 done SHALL be a registered pulse in the cycle after the final FSM state, i.e. cycle 3 for loads, 2 for word stores, 4 for sub-word stores, counting the accept edge as the start of cycle 1.
REQ-011 Misaligned (half with addr[0]=1; word with addr[1:0]!=0): no memory access, rdata unchanged, done=misaligned=1 in cycle 1.
REQ-012 req SHALL be ignored while busy=1; a req in the cycle done=1 (state IDLE) SHALL be accepted (back-to-back).
REQ-013 busy SHALL be decoded from state, with no registered delay.

Reset
REQ-014 While reset=1, state SHALL be IDLE and busy, done, misaligned, rdata, mem_addr, mem_din, mem_wen, mem_ren and all latched operands SHALL be 0.
REQ-015 Reset asserted mid-operation SHALL abort immediately and asynchronously: mem_wen drops in the same cycle, no done pulse follows, and the memory write is not completed.

Verification
REQ-016 The bench SHALL cover:
- Word store addr=0x3C, wdata=0xCAFEBABE -> mem_wen=1, mem_addr=15, mem_din=0xCAFEBABE in cycle 1; done in cycle 2; then LW 0x3C -> rdata=0xCAFEBABE, done in cycle 3.
- Memory word 100 = 0x12345678; SB addr=0x191, wdata=0xAA -> mem_din=0x1234AA78, done in cycle 4.
- Memory word 100 = 0x12345678; LB 0x193 -> rdata=0x00000012; LH 0x192 then word=0x8001xxxx -> rdata=0xFFFF8001; LHU same -> rdata=0x00008001.
- LW addr=0x3E -> misaligned=done=1 in cycle 1, mem_ren=mem_wen=0 throughout, rdata unchanged.
- req held high continuously with alternating SW/LW -> each accepted in its done cycle, never while busy=1.
- Reset asserted during the WR cycle of an SH -> mem_wen falls in the same cycle, no done, and a subsequent LW returns the old word.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: sub-word loads with sign/zero extension and read-modify-write
// sub-word stores against a single-port word-addressed data memory.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] rdata,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_wen,
  output logic        mem_ren,
  input  logic [31:0] mem_dout
);

  localparam int unsigned AW = 10;
  localparam int unsigned LW = 12;

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t      state, next_state;
  logic [LW-1:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        store_q;
  logic        unsigned_q;

  logic          accept;
  logic          misaligned_c;
  logic          done_d, misaligned_d, mem_wen_d, mem_ren_d;
  logic [31:0]   rdata_d, mem_din_d;
  logic [AW-1:0] mem_addr_d;
  logic [AW-1:0] word_addr;

  // Upper address bits are don't-care for this memory size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:LW];

  assign busy = (state != IDLE);

  assign misaligned_c = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));

  // Select the addressed lane and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    if (sz[1])             load_ext = word;
    else if (sz == 2'b00)  load_ext = uns ? {24'd0, b} : {{24{b[7]}}, b};
    else                   load_ext = uns ? {16'd0, h} : {{16{h[15]}}, h};
  endfunction

  // Replace the addressed lane of word with the low bits of data.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] off,
                                        input logic [1:0] sz, input logic [31:0] data);
    logic [31:0] r;
    r = word;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = data[15:0];
    end else begin
      r[15:0] = data[15:0];
    end
    merge = r;
  endfunction

  // Next state plus next values of every registered output.
  always_comb begin
    next_state   = state;
    accept       = 1'b0;
    done_d       = 1'b0;
    misaligned_d = 1'b0;
    rdata_d      = rdata;
    mem_din_d    = 32'd0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (misaligned_c) begin
            done_d       = 1'b1;
            misaligned_d = 1'b1;
          end else if (is_store && size[1]) begin
            next_state = WR;
            mem_din_d  = wdata;
          end else begin
            next_state = RD;
          end
        end
      end
      RD: next_state = CAP;
      CAP: begin
        if (store_q) begin
          next_state = WR;
          mem_din_d  = merge(mem_dout, addr_q[1:0], size_q, wdata_q);
        end else begin
          next_state = IDLE;
          done_d     = 1'b1;
          rdata_d    = load_ext(mem_dout, addr_q[1:0], size_q, unsigned_q);
        end
      end
      WR: begin
        next_state = IDLE;
        done_d     = 1'b1;
      end
      default: next_state = IDLE;
    endcase
    word_addr  = accept ? addr[LW-1:2] : addr_q[LW-1:2];
    mem_ren_d  = (next_state == RD) || (next_state == CAP);
    mem_wen_d  = (next_state == WR);
    mem_addr_d = (next_state != IDLE) ? word_addr : AW'(0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_wen    <= 1'b0;
      mem_ren    <= 1'b0;
    end else begin
      state      <= next_state;
      done       <= done_d;
      misaligned <= misaligned_d;
      rdata      <= rdata_d;
      mem_addr   <= mem_addr_d;
      mem_din    <= mem_din_d;
      mem_wen    <= mem_wen_d;
      mem_ren    <= mem_ren_d;
      if (accept) begin
        addr_q     <= addr[LW-1:0];
        wdata_q    <= wdata;
        size_q     <= size;
        store_q    <= is_store;
        unsigned_q <= unsigned_ld;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: per-cycle comparison against a word-array
// model of memory and a latency/lane model of each access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset, req, is_store, unsigned_ld;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, misaligned, mem_wen, mem_ren;
  logic [31:0] rdata, mem_din, mem_dout;
  logic [9:0]  mem_addr;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req(req), .is_store(is_store), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .misaligned(misaligned), .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous data memory and the model's own view of it.
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_din;
    if (mem_ren) mem_dout <= mem[mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  logic        check_en;
  logic        exp_busy, exp_done, exp_mis, exp_ren, exp_wen;
  logic [9:0]  exp_addr;
  logic [31:0] exp_din, exp_rdata;
  logic [31:0] last_din;
  logic [9:0]  last_addr;
  int          done_cyc;
  logic        mis_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("misaligned", 32'(misaligned), 32'(exp_mis));
      chk("mem_ren", 32'(mem_ren), 32'(exp_ren));
      chk("mem_wen", 32'(mem_wen), 32'(exp_wen));
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("mem_din", mem_din, exp_din);
      chk("rdata", rdata, exp_rdata);
    end
    if (mem_wen) begin
      last_din  = mem_din;
      last_addr = mem_addr;
    end
  end

  task automatic set_idle_exp();
    exp_busy = 1'b0; exp_done = 1'b0; exp_mis = 1'b0;
    exp_ren = 1'b0; exp_wen = 1'b0; exp_addr = '0; exp_din = '0;
  endtask

  task automatic idle_cycle();
    req = 1'b0;
    @(posedge clk); #1;
    set_idle_exp();
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  // Issue one access and set per-cycle expectations until its done cycle.
  task automatic op(input logic st, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] wd, input logic hold);
    int nb, sh, lat, idx;
    logic mis;
    logic [31:0] mask, old, nw, ld;
    mis  = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    sh   = 8 * int'(a[1:0]);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (nb * 8)) - 32'd1);
    idx  = int'(a[11:2]);
    old  = ref_mem[idx];
    nw   = (old & ~(mask << sh)) | ((wd & mask) << sh);
    ld   = (old >> sh) & mask;
    if (!uns && nb < 4 && ld[nb*8-1]) ld = ld | ~mask;
    lat  = mis ? 1 : !st ? 3 : (nb == 4) ? 2 : 4;
    is_store = st; size = sz; unsigned_ld = uns; addr = a; wdata = wd; req = 1'b1;
    done_cyc = 0; mis_seen = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (!hold) req = 1'b0;
      exp_busy = (k < lat);
      exp_done = (k == lat);
      exp_mis  = mis && (k == lat);
      exp_ren  = !mis && (!st || nb < 4) && (k <= 2);
      exp_wen  = !mis && st && (k == lat - 1);
      exp_addr = (exp_ren || exp_wen) ? a[11:2] : 10'd0;
      exp_din  = exp_wen ? nw : 32'd0;
      if (!mis && !st && k == lat) exp_rdata = ld;
      if (done === 1'b1 && done_cyc == 0) done_cyc = k;
      if (misaligned === 1'b1) mis_seen = 1'b1;
    end
    if (!mis && st) ref_mem[idx] = nw;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1; req = 1'b0; is_store = 1'b0; size = 2'd0; unsigned_ld = 1'b0;
    addr = '0; wdata = '0; mem_dout = '0;
    last_din = '0; last_addr = '0;
    exp_rdata = '0;
    set_idle_exp();
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle_cycle();

    // Word store then load back-to-back.
    op(1'b1, 2'd2, 1'b0, 32'h0000_003C, 32'hCAFE_BABE, 1'b0);
    chk("sw_done_cycle", 32'(done_cyc), 32'd2);
    chk("sw_mem_din", last_din, 32'hCAFE_BABE);
    chk("sw_mem_addr", 32'(last_addr), 32'd15);
    op(1'b0, 2'd2, 1'b0, 32'h0000_003C, 32'h0, 1'b0);
    chk("lw_done_cycle", 32'(done_cyc), 32'd3);
    chk("lw_rdata", rdata, 32'hCAFE_BABE);
    idle_cycle();

    // Byte store read-modify-write.
    preload(100, 32'h1234_5678);
    op(1'b1, 2'd0, 1'b0, 32'h0000_0191, 32'h0000_00AA, 1'b0);
    chk("sb_done_cycle", 32'(done_cyc), 32'd4);
    chk("sb_mem_din", last_din, 32'h1234_AA78);
    idle_cycle();
    chk("sb_mem_word", mem[100], 32'h1234_AA78);

    // Sub-word loads with extension.
    preload(100, 32'h1234_5678);
    op(1'b0, 2'd0, 1'b0, 32'h0000_0193, 32'h0, 1'b0);
    chk("lb_rdata", rdata, 32'h0000_0012);
    preload(100, 32'h8001_5678);
    op(1'b0, 2'd1, 1'b0, 32'h0000_0192, 32'h0, 1'b0);
    chk("lh_rdata", rdata, 32'hFFFF_8001);
    op(1'b0, 2'd1, 1'b1, 32'h0000_0192, 32'h0, 1'b0);
    chk("lhu_rdata", rdata, 32'h0000_8001);
    op(1'b0, 2'd0, 1'b0, 32'h0000_0193, 32'h0, 1'b0);
    chk("lb_neg_rdata", rdata, 32'hFFFF_FF80);
    op(1'b1, 2'd1, 1'b0, 32'h0000_0192, 32'h1234_BEEF, 1'b0);
    chk("sh_mem_din", last_din, 32'hBEEF_5678);
    op(1'b0, 2'd3, 1'b0, 32'h0000_0190, 32'h0, 1'b0);
    chk("lw_size3_rdata", rdata, 32'hBEEF_5678);
    idle_cycle();

    // Misaligned accesses leave rdata alone.
    op(1'b0, 2'd2, 1'b0, 32'h0000_003E, 32'h0, 1'b0);
    chk("mis_done_cycle", 32'(done_cyc), 32'd1);
    chk("mis_flag", 32'(mis_seen), 32'd1);
    chk("mis_rdata", rdata, 32'hBEEF_5678);
    op(1'b1, 2'd1, 1'b0, 32'h0000_0191, 32'hFFFF, 1'b0);
    chk("mis_sh_flag", 32'(mis_seen), 32'd1);
    idle_cycle();

    // req held high continuously across alternating stores and loads.
    for (int i = 0; i < 4; i++) begin
      op(1'b1, 2'd2, 1'b0, 32'h200 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 1'b1);
      chk("held_sw_done", 32'(done_cyc), 32'd2);
      op(1'b0, 2'd2, 1'b0, 32'h200 + 32'(i * 4), 32'h0, 1'b1);
      chk("held_lw_done", 32'(done_cyc), 32'd3);
      chk("held_lw_rdata", rdata, 32'hA5A5_0000 + 32'(i));
    end
    idle_cycle();
    idle_cycle();

    // Reset during the write cycle of a half store aborts the write.
    preload(50, 32'h1122_3344);
    check_en = 1'b0;
    is_store = 1'b1; size = 2'd1; unsigned_ld = 1'b0; addr = 32'h0000_00C8; wdata = 32'h0000_5555;
    req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    chk("abort_rd_ren", 32'(mem_ren), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_wr_wen", 32'(mem_wen), 32'd1);
    chk("abort_wr_din", mem_din, 32'h1122_5555);
    #2 reset = 1'b1;
    #1;
    chk("abort_wen_low", 32'(mem_wen), 32'd0);
    chk("abort_busy_low", 32'(busy), 32'd0);
    chk("abort_din_zero", mem_din, 32'd0);
    chk("abort_rdata_zero", rdata, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    exp_rdata = '0;
    set_idle_exp();
    check_en = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_mem_word", mem[50], 32'h1122_3344);
    op(1'b0, 2'd2, 1'b0, 32'h0000_00C8, 32'h0, 1'b0);
    chk("abort_lw_rdata", rdata, 32'h1122_3344);
    idle_cycle();
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
